// File: rtl/seq_normalizer.sv
// seq_normalizer -- iterative leading-zero normalizer.
//
// Captures a 32-bit operand on start and shifts it left one bit per clock
// until bit 31 is set. Reports the shifted value, the number of shifts
// applied (the leading-zero count of the operand) and a zero flag. An
// operand that is zero or already normalized completes without shifting.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request, sampled only in IDLE
//   d_in    in  32   operand, captured on the accepting edge
//   busy    out  1   operation in progress (SHIFT or FIN)
//   done    out  1   one-cycle pulse, results valid
//   d_out   out 32   normalized operand
//   sh_amt  out  5   left-shift count applied
//   zero    out  1   captured operand was zero
module seq_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] d_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] d_out,
  output logic [4:0]  sh_amt,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] work;
  logic [4:0]  cnt;

  // Operands that need no shifting go straight to FIN.
  logic load_done;
  assign load_done = (d_in == 32'd0) || d_in[31];

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from pre-edge values; blocking here would
  // make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so every path assigns
  // it; a missing assignment in combinational logic infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = load_done ? FIN : SHIFT;
        end
      end
      SHIFT: begin
        // Bit 30 set now means this shift lands a 1 in bit 31.
        if (work[30]) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register only; start and d_in never
  // reach an output without passing through a flop.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT: busy = 1'b1;
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: working register, shift counter and result registers.
  // Results are written only on the edge that enters FIN, so they hold
  // their previous values throughout SHIFT and after returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= 32'd0;
      cnt    <= 5'd0;
      d_out  <= 32'd0;
      sh_amt <= 5'd0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= d_in;
            cnt  <= 5'd0;
            if (load_done) begin
              d_out  <= d_in;
              sh_amt <= 5'd0;
              zero   <= (d_in == 32'd0);
            end
          end
        end
        SHIFT: begin
          // A nonzero operand has at most 31 leading zeros, so the counter
          // peaks at 31 on the final shift and never wraps.
          work <= {work[30:0], 1'b0};
          cnt  <= cnt + 5'd1;
          if (work[30]) begin
            d_out  <= {work[30:0], 1'b0};
            sh_amt <= cnt + 5'd1;
            zero   <= 1'b0;
          end
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
// tb_seq_normalizer -- directed self-checking bench for seq_normalizer.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_seq_normalizer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] d_in;
  logic        busy;
  logic        done;
  logic [31:0] d_out;
  logic [4:0]  sh_amt;
  logic        zero;

  int checks = 0;
  int errors = 0;

  // Last completed result, used to confirm outputs hold during SHIFT.
  logic [31:0] last_dout = 32'd0;

  seq_normalizer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .d_in   (d_in),
    .busy   (busy),
    .done   (done),
    .d_out  (d_out),
    .sh_amt (sh_amt),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it to completion. Edge 1 is the
  // accepting edge; latency is the edge count at which done is first seen.
  // A nonzero pulse_at raises start with 0xFFFFFFFF after that edge.
  task automatic run_op(input string tag, input logic [31:0] din,
                        input logic [31:0] exp_dout, input logic [4:0] exp_sh,
                        input logic exp_zero, input int exp_lat, input int pulse_at);
    int n;
    start = 1'b1;
    d_in  = din;
    tick();
    n     = 1;
    start = 1'b0;
    d_in  = ~din;
    if (exp_lat > 1) begin
      check({tag, "_busy_shift"}, 32'(busy), 32'd1);
      check({tag, "_hold_shift"}, d_out, last_dout);
    end
    while (!done && n < 40) begin
      if (n == pulse_at) begin
        start = 1'b1;
        d_in  = 32'hFFFF_FFFF;
      end
      tick();
      n++;
      start = 1'b0;
      d_in  = $urandom;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_fin"}, 32'(busy), 32'd1);
    check({tag, "_d_out"}, d_out, exp_dout);
    check({tag, "_sh_amt"}, 32'(sh_amt), 32'(exp_sh));
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    last_dout = exp_dout;
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold_idle"}, d_out, exp_dout);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    d_in  = 32'd0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d_out", d_out, 32'd0);
    check("rst_sh_amt", 32'(sh_amt), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    #13 rst_n = 1'b1;
    tick();

    run_op("msb_set",   32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0, 1,  0);
    run_op("lsb_only",  32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0, 32, 0);
    run_op("mid",       32'h0001_2345, 32'h91A2_8000, 5'd15, 1'b0, 16, 0);
    run_op("zero_op",   32'h0000_0000, 32'h0000_0000, 5'd0,  1'b1, 1,  0);
    run_op("all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b0, 1,  0);
    run_op("ign_start", 32'h0000_0100, 32'h8000_0000, 5'd23, 1'b0, 24, 5);

    // start held high: accepted, FIN, one IDLE cycle, accepted again.
    start = 1'b1;
    d_in  = 32'h4000_0000;
    tick();
    check("b2b_busy1", 32'(busy), 32'd1);
    tick();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_sh1", 32'(sh_amt), 32'd1);
    tick();
    check("b2b_idle", 32'(busy), 32'd0);
    d_in = 32'h0000_0003;
    tick();
    check("b2b_busy2", 32'(busy), 32'd1);
    start = 1'b0;
    d_in  = 32'd0;
    while (!done && checks < 10000) begin
      tick();
      if (busy === 1'b0) break;
    end
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_d_out2", d_out, 32'hC000_0000);
    check("b2b_sh2", 32'(sh_amt), 32'd30);
    last_dout = 32'hC000_0000;
    tick();

    // Reset in the middle of a long operation aborts it.
    start = 1'b1;
    d_in  = 32'h0000_0001;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_d_out", d_out, 32'd0);
    check("abort_sh_amt", 32'(sh_amt), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    tick();
    #4 rst_n = 1'b1;
    tick();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    last_dout = 32'd0;

    run_op("post_rst", 32'h4000_0000, 32'h8000_0000, 5'd1, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
